apb_timeout_bridge: RTL and testbench

//  APB fan-out bridge for 4 kB peripheral segments: decodes one upstream APB completer port into NUM_PORTS

---
 rtl/apb_bridge_pkg.sv | 19 +
 rtl/apb_bridge_decoder.sv | 27 ++
 rtl/apb_timeout_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_apb_timeout_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the APB fan-out bridges.
package apb_bridge_pkg;

    localparam int unsigned ERR_COUNT_WIDTH = 16;
    localparam int unsigned APB_ADDR_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE,
        DSETUP,
        DACCESS,
        RESP
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_COUNT_WIDTH-1:0] sat_inc(input logic [ERR_COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + ERR_COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/apb_bridge_decoder.sv
// Maps an upstream APB address onto a downstream port index and block-local address.
module apb_bridge_decoder
    import apb_bridge_pkg::*;
#(
    parameter int unsigned  NUM_PORTS  = 4,
    parameter logic [31:0]  BASE_ADDR  = 32'h0,
    parameter int unsigned  BLOCK_SIZE = 32'h1000,
    localparam int unsigned LOCAL_AW   = $clog2(BLOCK_SIZE),
    localparam int unsigned IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [APB_ADDR_WIDTH-1:0] i_paddr,
    output logic                      o_hit_c,
    output logic [IDX_W-1:0]          o_idx_c,
    output logic [LOCAL_AW-1:0]       o_local_addr_c
);

    logic [APB_ADDR_WIDTH-1:0] w_offset;
    logic [APB_ADDR_WIDTH-1:0] w_block;

    assign w_offset       = i_paddr - BASE_ADDR;
    assign w_block        = w_offset >> LOCAL_AW;
    // Below-base addresses wrap to huge offsets, so the lower bound is checked explicitly.
    assign o_hit_c        = (i_paddr >= BASE_ADDR) && (w_block < NUM_PORTS);
    assign o_idx_c        = IDX_W'(w_block);
    assign o_local_addr_c = i_paddr[LOCAL_AW-1:0];

endmodule

// File: rtl/apb_timeout_bridge.sv
// APB fan-out bridge: one upstream completer to NUM_PORTS registered requesters,
// with decode-miss errors, a per-access watchdog and a saturating error counter.
module apb_timeout_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned  NUM_PORTS      = 4,
    parameter logic [31:0]  BASE_ADDR      = 32'h0,
    parameter int unsigned  BLOCK_SIZE     = 32'h1000,
    parameter int unsigned  DATA_WIDTH     = 32,
    parameter int unsigned  TIMEOUT_CYCLES = 256,
    localparam int unsigned DN_AW          = $clog2(BLOCK_SIZE),
    localparam int unsigned STRB_W         = DATA_WIDTH / 8
) (
    input  logic                                   pclk,
    input  logic                                   preset_n,
    input  logic                                   i_psel,
    input  logic                                   i_penable,
    input  logic                                   i_pwrite,
    input  logic [APB_ADDR_WIDTH-1:0]              i_paddr,
    input  logic [DATA_WIDTH-1:0]                  i_pwdata,
    input  logic [STRB_W-1:0]                      i_pstrb,
    input  logic [2:0]                             i_pprot,
    output logic                                   o_pready,
    output logic                                   o_pslverr,
    output logic [DATA_WIDTH-1:0]                  o_prdata,
    output logic [NUM_PORTS-1:0]                   o_dn_psel,
    output logic [NUM_PORTS-1:0]                   o_dn_penable,
    output logic [NUM_PORTS-1:0]                   o_dn_pwrite,
    output logic [NUM_PORTS-1:0][DN_AW-1:0]        o_dn_paddr,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   o_dn_pwdata,
    output logic [NUM_PORTS-1:0][STRB_W-1:0]       o_dn_pstrb,
    output logic [NUM_PORTS-1:0][2:0]              o_dn_pprot,
    input  logic [NUM_PORTS-1:0]                   i_dn_pready,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   i_dn_prdata,
    input  logic [NUM_PORTS-1:0]                   i_dn_pslverr,
    output logic                                   o_decode_err,
    output logic                                   o_timeout_err,
    output logic [ERR_COUNT_WIDTH-1:0]             o_err_count
);

    localparam int unsigned IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned WD_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit  WD_EN   = (TIMEOUT_CYCLES != 0);

    state_t                     r_state,       w_state_nxt;
    logic [NUM_PORTS-1:0]       r_dn_psel,     w_dn_psel_nxt;
    logic [NUM_PORTS-1:0]       r_dn_penable,  w_dn_penable_nxt;
    logic [DN_AW-1:0]           r_paddr,       w_paddr_nxt;
    logic                       r_pwrite,      w_pwrite_nxt;
    logic [DATA_WIDTH-1:0]      r_pwdata,      w_pwdata_nxt;
    logic [STRB_W-1:0]          r_pstrb,       w_pstrb_nxt;
    logic [2:0]                 r_pprot,       w_pprot_nxt;
    logic [WD_W-1:0]            r_wd,          w_wd_nxt;
    logic                       r_pready,      w_pready_nxt;
    logic                       r_pslverr,     w_pslverr_nxt;
    logic [DATA_WIDTH-1:0]      r_prdata,      w_prdata_nxt;
    logic                       r_decode_err,  w_decode_err_nxt;
    logic                       r_timeout_err, w_timeout_err_nxt;
    logic [ERR_COUNT_WIDTH-1:0] r_err_count,   w_err_count_nxt;

    logic                       w_hit;
    logic [IDX_W-1:0]           w_idx;
    logic [DN_AW-1:0]           w_local_addr;
    logic [NUM_PORTS-1:0]       w_onehot;
    logic                       w_sel_pready;
    logic                       w_sel_pslverr;
    logic [DATA_WIDTH-1:0]      w_sel_prdata;
    logic                       w_wd_expired;

    apb_bridge_decoder #(
        .NUM_PORTS  (NUM_PORTS),
        .BASE_ADDR  (BASE_ADDR),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_decoder (
        .i_paddr        (i_paddr),
        .o_hit_c        (w_hit),
        .o_idx_c        (w_idx),
        .o_local_addr_c (w_local_addr)
    );

    // Response mux: only the port we selected can complete the access.
    always_comb begin
        w_sel_pready  = |(i_dn_pready & r_dn_psel);
        w_sel_pslverr = |(i_dn_pslverr & r_dn_psel);
        w_sel_prdata  = '0;
        w_onehot      = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (r_dn_psel[i]) begin
                w_sel_prdata = w_sel_prdata | i_dn_prdata[i];
            end
            w_onehot[i] = (w_idx == IDX_W'(i));
        end
    end

    assign w_wd_expired = WD_EN && (r_wd == WD_LAST);

    always_comb begin
        w_state_nxt       = r_state;
        w_dn_psel_nxt     = r_dn_psel;
        w_dn_penable_nxt  = r_dn_penable;
        w_paddr_nxt       = r_paddr;
        w_pwrite_nxt      = r_pwrite;
        w_pwdata_nxt      = r_pwdata;
        w_pstrb_nxt       = r_pstrb;
        w_pprot_nxt       = r_pprot;
        w_wd_nxt          = r_wd;
        w_pready_nxt      = r_pready;
        w_pslverr_nxt     = r_pslverr;
        w_prdata_nxt      = r_prdata;
        w_decode_err_nxt  = 1'b0;
        w_timeout_err_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    if (w_hit) begin
                        w_dn_psel_nxt = w_onehot;
                        w_paddr_nxt   = w_local_addr;
                        w_pwrite_nxt  = i_pwrite;
                        w_pwdata_nxt  = i_pwdata;
                        w_pstrb_nxt   = i_pstrb;
                        w_pprot_nxt   = i_pprot;
                        w_state_nxt   = DSETUP;
                    end else begin
                        w_pready_nxt     = 1'b1;
                        w_pslverr_nxt    = 1'b1;
                        w_prdata_nxt     = '0;
                        w_decode_err_nxt = 1'b1;
                        w_state_nxt      = RESP;
                    end
                end
            end
            DSETUP: begin
                w_dn_penable_nxt = r_dn_psel;
                w_wd_nxt         = '0;
                w_state_nxt      = DACCESS;
            end
            DACCESS: begin
                if (w_sel_pready) begin
                    w_prdata_nxt     = r_pwrite ? '0 : w_sel_prdata;
                    w_pslverr_nxt    = w_sel_pslverr;
                    w_pready_nxt     = 1'b1;
                    w_dn_psel_nxt    = '0;
                    w_dn_penable_nxt = '0;
                    w_state_nxt      = RESP;
                end else if (w_wd_expired) begin
                    w_prdata_nxt      = '0;
                    w_pslverr_nxt     = 1'b1;
                    w_pready_nxt      = 1'b1;
                    w_timeout_err_nxt = 1'b1;
                    w_dn_psel_nxt     = '0;
                    w_dn_penable_nxt  = '0;
                    w_state_nxt       = RESP;
                end else begin
                    w_wd_nxt = r_wd + WD_W'(1);
                end
            end
            RESP: begin
                // Hold the response until the upstream requester is in its access phase.
                if (i_penable) begin
                    w_pready_nxt  = 1'b0;
                    w_pslverr_nxt = 1'b0;
                    w_prdata_nxt  = '0;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_err_count_nxt = (w_decode_err_nxt || w_timeout_err_nxt) ? sat_inc(r_err_count) : r_err_count;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state       <= IDLE;
            r_dn_psel     <= '0;
            r_dn_penable  <= '0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_pprot       <= '0;
            r_wd          <= '0;
            r_pready      <= 1'b0;
            r_pslverr     <= 1'b0;
            r_prdata      <= '0;
            r_decode_err  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_dn_psel     <= w_dn_psel_nxt;
            r_dn_penable  <= w_dn_penable_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_pstrb       <= w_pstrb_nxt;
            r_pprot       <= w_pprot_nxt;
            r_wd          <= w_wd_nxt;
            r_pready      <= w_pready_nxt;
            r_pslverr     <= w_pslverr_nxt;
            r_prdata      <= w_prdata_nxt;
            r_decode_err  <= w_decode_err_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_err_count   <= w_err_count_nxt;
        end
    end

    // Request fields are broadcast; psel alone qualifies which port is addressed.
    for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_port
        assign o_dn_paddr[g]  = r_paddr;
        assign o_dn_pwdata[g] = r_pwdata;
        assign o_dn_pstrb[g]  = r_pstrb;
        assign o_dn_pprot[g]  = r_pprot;
        assign o_dn_pwrite[g] = r_pwrite;
    end

    assign o_dn_psel     = r_dn_psel;
    assign o_dn_penable  = r_dn_penable;
    assign o_pready      = r_pready;
    assign o_pslverr     = r_pslverr;
    assign o_prdata      = r_prdata;
    assign o_decode_err  = r_decode_err;
    assign o_timeout_err = r_timeout_err;
    assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_apb_timeout_bridge.sv
// Scoreboard bench for apb_timeout_bridge: APB requester upstream, configurable completers downstream.
module tb_apb_timeout_bridge;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          TO   = 16;

    typedef struct packed {
        int          lat;
        logic [31:0] rdata;
        logic        slverr;
        logic [3:0]  mask;
        logic [11:0] dpaddr;
        int          acc;
        logic        err;
    } exp_t;

    typedef struct packed {
        int          lat;
        logic [31:0] rdata;
        logic        slverr;
        logic [3:0]  seen;
        logic [11:0] dpaddr;
        logic [31:0] dwdata;
        logic [3:0]  dstrb;
        logic        dwrite;
        int          acc;
        int          dec;
        int          tmo;
        logic        pready_after;
    } obs_t;

    logic              pclk, preset_n;
    logic              up_psel, up_penable, up_pwrite, up_pready, up_pslverr;
    logic [31:0]       up_paddr, up_pwdata, up_prdata;
    logic [3:0]        up_pstrb;
    logic [2:0]        up_pprot;
    logic [3:0]        dn_psel, dn_penable, dn_pwrite, dn_pready, dn_pslverr;
    logic [3:0][11:0]  dn_paddr;
    logic [3:0][31:0]  dn_pwdata, dn_prdata;
    logic [3:0][3:0]   dn_pstrb;
    logic [3:0][2:0]   dn_pprot;
    logic              dec_err, to_err;
    logic [15:0]       err_count;

    logic [3:0]        hang, force_rdy, err_cfg;
    int                wait_st [4];
    logic [31:0]       mem [4];
    int                cnt [4];

    exp_t              sb[$];
    logic [15:0]       exp_err;
    int                n_cmp = 0;
    int                n_bad = 0;

    apb_timeout_bridge #(
        .NUM_PORTS      (4),
        .BASE_ADDR      (BASE),
        .BLOCK_SIZE     (32'h1000),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk          (pclk),
        .preset_n      (preset_n),
        .i_psel        (up_psel),
        .i_penable     (up_penable),
        .i_pwrite      (up_pwrite),
        .i_paddr       (up_paddr),
        .i_pwdata      (up_pwdata),
        .i_pstrb       (up_pstrb),
        .i_pprot       (up_pprot),
        .o_pready      (up_pready),
        .o_pslverr     (up_pslverr),
        .o_prdata      (up_prdata),
        .o_dn_psel     (dn_psel),
        .o_dn_penable  (dn_penable),
        .o_dn_pwrite   (dn_pwrite),
        .o_dn_paddr    (dn_paddr),
        .o_dn_pwdata   (dn_pwdata),
        .o_dn_pstrb    (dn_pstrb),
        .o_dn_pprot    (dn_pprot),
        .i_dn_pready   (dn_pready),
        .i_dn_prdata   (dn_prdata),
        .i_dn_pslverr  (dn_pslverr),
        .o_decode_err  (dec_err),
        .o_timeout_err (to_err),
        .o_err_count   (err_count)
    );

    always #5 pclk = ~pclk;

    // Downstream completers: wait_st wait states, or hang forever; force_rdy drives a stray pready.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            dn_pready[p]  = force_rdy[p] | (dn_psel[p] & dn_penable[p] & ~hang[p] & (cnt[p] >= wait_st[p]));
            dn_prdata[p]  = mem[p];
            dn_pslverr[p] = err_cfg[p];
        end
    end

    always @(posedge pclk) begin
        for (int p = 0; p < 4; p++) begin
            if (dn_psel[p] && dn_penable[p] && !dn_pready[p]) cnt[p] <= cnt[p] + 1;
            else cnt[p] <= 0;
        end
    end

    function automatic exp_t model(input logic [31:0] addr, input logic wr);
        exp_t        e;
        logic [31:0] off, blk;
        int          p;
        e   = '0;
        off = addr - BASE;
        blk = off >> 12;
        if (addr < BASE || blk >= 32'd4) begin
            e.lat = 1; e.slverr = 1'b1; e.err = 1'b1;
        end else begin
            p        = int'(blk);
            e.mask   = 4'(1 << p);
            e.dpaddr = addr[11:0];
            if (hang[p]) begin
                e.lat = TO + 2; e.slverr = 1'b1; e.err = 1'b1; e.acc = TO;
            end else begin
                e.lat    = 3 + wait_st[p];
                e.slverr = err_cfg[p];
                e.rdata  = wr ? 32'h0 : mem[p];
                e.acc    = wait_st[p] + 1;
            end
        end
        return e;
    endfunction

    // Upstream requester: setup phase, then access phase until pready (bounded).
    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] st, output obs_t o);
        o     = '0;
        o.lat = -1;
        @(negedge pclk);
        up_psel = 1'b1; up_penable = 1'b0; up_paddr = addr; up_pwrite = wr;
        up_pwdata = wd; up_pstrb = st; up_pprot = 3'b010;
        for (int k = 1; k <= 100; k++) begin
            @(posedge pclk); @(negedge pclk);
            up_penable = 1'b1;
            o.seen |= dn_psel;
            o.dec  += int'(dec_err);
            o.tmo  += int'(to_err);
            for (int p = 0; p < 4; p++) begin
                if (dn_psel[p] && dn_penable[p]) begin
                    o.acc++;
                    o.dpaddr = dn_paddr[p]; o.dwdata = dn_pwdata[p];
                    o.dstrb  = dn_pstrb[p]; o.dwrite = dn_pwrite[p];
                end
            end
            if (up_pready) begin
                o.lat = k; o.rdata = up_prdata; o.slverr = up_pslverr;
                break;
            end
        end
        @(posedge pclk); @(negedge pclk);
        up_psel = 1'b0; up_penable = 1'b0;
        o.seen |= dn_psel;
        o.dec  += int'(dec_err);
        o.tmo  += int'(to_err);
        o.pready_after = up_pready;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pclk);
        n_cmp++; if ({dn_psel, dn_penable, dn_pwrite} !== 12'h0) begin n_bad++; $display("FAIL rst_dn_ctrl got %0h want 0", {dn_psel, dn_penable, dn_pwrite}); end
        n_cmp++; if ({dn_paddr, dn_pwdata, dn_pstrb} !== '0) begin n_bad++; $display("FAIL rst_dn_data got nonzero want 0"); end
        n_cmp++; if ({up_pready, up_pslverr, up_prdata} !== 34'h0) begin n_bad++; $display("FAIL rst_up got %0h want 0", {up_pready, up_pslverr, up_prdata}); end
        n_cmp++; if ({dec_err, to_err, err_count} !== 18'h0) begin n_bad++; $display("FAIL rst_err got %0h want 0", {dec_err, to_err, err_count}); end
        preset_n = 1'b1;
        exp_err  = 16'h0;
    endtask

    task automatic test_read_zero_wait();
        obs_t o; exp_t e;
        sb.push_back(model(BASE + 32'h2004, 1'b0));
        apb_xfer(BASE + 32'h2004, 1'b0, 32'h0, 4'h0, o);
        e = sb.pop_front();
        n_cmp++; if (o.lat !== e.lat) begin n_bad++; $display("FAIL rd2_latency got %0d want %0d", o.lat, e.lat); end
        n_cmp++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL rd2_prdata got %h want %h", o.rdata, e.rdata); end
        n_cmp++; if (o.slverr !== e.slverr) begin n_bad++; $display("FAIL rd2_pslverr got %b want %b", o.slverr, e.slverr); end
        n_cmp++; if (o.seen !== e.mask) begin n_bad++; $display("FAIL rd2_psel_mask got %b want %b", o.seen, e.mask); end
        n_cmp++; if (o.dpaddr !== e.dpaddr) begin n_bad++; $display("FAIL rd2_dn_paddr got %h want %h", o.dpaddr, e.dpaddr); end
        n_cmp++; if (o.acc !== e.acc) begin n_bad++; $display("FAIL rd2_access_cycles got %0d want %0d", o.acc, e.acc); end
        n_cmp++; if (o.pready_after !== 1'b0) begin n_bad++; $display("FAIL rd2_pready_one_cycle got %b want 0", o.pready_after); end
    endtask

    task automatic test_write_wait_states();
        obs_t o; exp_t e;
        wait_st[0] = 5;
        sb.push_back(model(BASE + 32'h0010, 1'b1));
        apb_xfer(BASE + 32'h0010, 1'b1, 32'hcafe_babe, 4'hf, o);
        e = sb.pop_front();
        n_cmp++; if (o.lat !== e.lat) begin n_bad++; $display("FAIL wr0_latency got %0d want %0d", o.lat, e.lat); end
        n_cmp++; if (o.seen !== e.mask) begin n_bad++; $display("FAIL wr0_psel_mask got %b want %b", o.seen, e.mask); end
        n_cmp++; if ({o.dwrite, o.dwdata, o.dstrb} !== {1'b1, 32'hcafe_babe, 4'hf}) begin n_bad++; $display("FAIL wr0_dn_fields got %h want %h", {o.dwrite, o.dwdata, o.dstrb}, {1'b1, 32'hcafe_babe, 4'hf}); end
        n_cmp++; if ({o.slverr, o.rdata} !== {e.slverr, e.rdata}) begin n_bad++; $display("FAIL wr0_resp got %h want %h", {o.slverr, o.rdata}, {e.slverr, e.rdata}); end
        n_cmp++; if (o.acc !== e.acc) begin n_bad++; $display("FAIL wr0_access_cycles got %0d want %0d", o.acc, e.acc); end
        n_cmp++; if (err_count !== exp_err) begin n_bad++; $display("FAIL wr0_err_count got %h want %h", err_count, exp_err); end
        wait_st[0] = 0;
    endtask

    task automatic test_slave_error();
        obs_t o; exp_t e;
        err_cfg[2] = 1'b1;
        sb.push_back(model(BASE + 32'h2ff8, 1'b0));
        apb_xfer(BASE + 32'h2ff8, 1'b0, 32'h0, 4'h0, o);
        e = sb.pop_front();
        n_cmp++; if ({o.lat, o.slverr, o.rdata} !== {e.lat, e.slverr, e.rdata}) begin n_bad++; $display("FAIL slverr_resp got %h want %h", {o.lat, o.slverr, o.rdata}, {e.lat, e.slverr, e.rdata}); end
        n_cmp++; if ({o.dec, o.tmo, err_count} !== {32'd0, 32'd0, exp_err}) begin n_bad++; $display("FAIL slverr_no_telemetry got %h want %h", {o.dec, o.tmo, err_count}, {32'd0, 32'd0, exp_err}); end
        err_cfg[2] = 1'b0;
    endtask

    task automatic test_decode_miss(input logic [31:0] addr, input int n);
        obs_t o; exp_t e;
        for (int i = 0; i < n; i++) begin
            sb.push_back(model(addr, 1'b0));
            apb_xfer(addr, 1'b0, 32'h0, 4'h0, o);
            e = sb.pop_front();
            if (e.err) exp_err = (exp_err == 16'hffff) ? exp_err : exp_err + 16'h1;
            n_cmp++; if ({o.lat, o.slverr, o.rdata} !== {e.lat, e.slverr, e.rdata}) begin n_bad++; $display("FAIL miss_resp addr=%h got %h want %h", addr, {o.lat, o.slverr, o.rdata}, {e.lat, e.slverr, e.rdata}); end
            n_cmp++; if (o.seen !== e.mask) begin n_bad++; $display("FAIL miss_no_dn_psel got %b want %b", o.seen, e.mask); end
            n_cmp++; if ({o.dec, o.tmo} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL miss_pulses got dec=%0d to=%0d want 1/0", o.dec, o.tmo); end
            n_cmp++; if (err_count !== exp_err) begin n_bad++; $display("FAIL miss_err_count got %h want %h", err_count, exp_err); end
        end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e;
        hang[1] = 1'b1;
        sb.push_back(model(BASE + 32'h1008, 1'b0));
        apb_xfer(BASE + 32'h1008, 1'b0, 32'h0, 4'h0, o);
        e = sb.pop_front();
        if (e.err) exp_err = exp_err + 16'h1;
        n_cmp++; if (o.lat !== e.lat) begin n_bad++; $display("FAIL to_latency got %0d want %0d", o.lat, e.lat); end
        n_cmp++; if (o.acc !== e.acc) begin n_bad++; $display("FAIL to_access_cycles got %0d want %0d", o.acc, e.acc); end
        n_cmp++; if ({o.slverr, o.rdata, o.seen} !== {e.slverr, e.rdata, e.mask}) begin n_bad++; $display("FAIL to_resp got %h want %h", {o.slverr, o.rdata, o.seen}, {e.slverr, e.rdata, e.mask}); end
        n_cmp++; if ({o.dec, o.tmo} !== {32'd0, 32'd1}) begin n_bad++; $display("FAIL to_pulses got dec=%0d to=%0d want 0/1", o.dec, o.tmo); end
        n_cmp++; if (err_count !== exp_err) begin n_bad++; $display("FAIL to_err_count got %h want %h", err_count, exp_err); end
        hang[1] = 1'b0;
    endtask

    task automatic test_late_pready();
        obs_t o; exp_t e;
        int   stray;
        stray = 0;
        force_rdy[1] = 1'b1;
        repeat (4) begin
            @(negedge pclk);
            stray += int'(up_pready) + int'(|dn_psel);
        end
        n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL late_pready_ignored got %0d want 0", stray); end
        sb.push_back(model(BASE + 32'h3ffc, 1'b0));
        apb_xfer(BASE + 32'h3ffc, 1'b0, 32'h0, 4'h0, o);
        e = sb.pop_front();
        n_cmp++; if ({o.lat, o.slverr, o.rdata, o.seen} !== {e.lat, e.slverr, e.rdata, e.mask}) begin n_bad++; $display("FAIL next_rd3 got %h want %h", {o.lat, o.slverr, o.rdata, o.seen}, {e.lat, e.slverr, e.rdata, e.mask}); end
        force_rdy[1] = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        obs_t o; exp_t e;
        logic reached;
        reached = 1'b0;
        hang[3] = 1'b1;
        @(negedge pclk);
        up_psel = 1'b1; up_penable = 1'b0; up_paddr = BASE + 32'h3000; up_pwrite = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge pclk); @(negedge pclk);
            up_penable = 1'b1;
            if (dn_psel[3] && dn_penable[3]) begin reached = 1'b1; break; end
        end
        n_cmp++; if (reached !== 1'b1) begin n_bad++; $display("FAIL rstmid_reached_access got %b want 1", reached); end
        preset_n = 1'b0;
        #1;
        n_cmp++; if ({dn_psel[3], dn_penable[3]} !== 2'b00) begin n_bad++; $display("FAIL rstmid_dn_drop got %b want 00", {dn_psel[3], dn_penable[3]}); end
        n_cmp++; if (err_count !== 16'h0) begin n_bad++; $display("FAIL rstmid_err_count got %h want 0", err_count); end
        up_psel = 1'b0; up_penable = 1'b0; hang[3] = 1'b0; exp_err = 16'h0;
        @(negedge pclk);
        preset_n = 1'b1;
        sb.push_back(model(BASE + 32'h3000, 1'b0));
        apb_xfer(BASE + 32'h3000, 1'b0, 32'h0, 4'h0, o);
        e = sb.pop_front();
        n_cmp++; if ({o.lat, o.slverr, o.rdata, o.seen} !== {e.lat, e.slverr, e.rdata, e.mask}) begin n_bad++; $display("FAIL rstmid_first_access got %h want %h", {o.lat, o.slverr, o.rdata, o.seen}, {e.lat, e.slverr, e.rdata, e.mask}); end
    endtask

    task automatic test_err_saturation();
        @(negedge pclk);
        force dut.r_err_count = 16'hfffe;
        @(posedge pclk); @(negedge pclk);
        release dut.r_err_count;
        exp_err = 16'hfffe;
        test_decode_miss(BASE + 32'h8000, 3);
    endtask

    initial begin
        pclk = 1'b0; preset_n = 1'b0;
        up_psel = 1'b0; up_penable = 1'b0; up_pwrite = 1'b0;
        up_paddr = '0; up_pwdata = '0; up_pstrb = '0; up_pprot = '0;
        hang = '0; force_rdy = '0; err_cfg = '0;
        for (int p = 0; p < 4; p++) wait_st[p] = 0;
        mem[0] = 32'h0000_aa00; mem[1] = 32'h1111_0001;
        mem[2] = 32'h1234_5678; mem[3] = 32'h3333_0003;
        exp_err = 16'h0;

        test_reset();
        test_read_zero_wait();
        test_write_wait_states();
        test_slave_error();
        test_decode_miss(BASE + 32'h4000, 1);
        test_decode_miss(32'h3fff_fffc, 1);
        test_timeout();
        test_late_pready();
        test_reset_mid_access();
        test_err_saturation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
